// File: rtl/fetch_branch_unit.sv
// Fetch stage, IF/ID pipeline register and D-stage next-PC resolution for a
// 5-stage MIPS pipeline. Branch/jump decisions are made in D from the
// comparator flags and decoded controls. A taken redirect steers fetch to
// the resolved target on the following edge.
module fetch_branch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          DELAY_SLOT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    input  logic        StallF,
    input  logic        StallD,
    input  logic [2:0]  BranchOpD,
    input  logic        JumpD,
    input  logic        JrD,
    input  logic        EqualD,
    input  logic        LtzD,
    input  logic [31:0] JrTargetD,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        RedirectD,
    output logic [15:0] BranchCountD
);

    // Without a delay slot, the instruction fetched alongside a redirect is
    // on the wrong path and must be turned into a nop in IF/ID.
    localparam bit SquashOnRedirect = (DELAY_SLOT == 0);

    localparam logic [2:0] OpNone = 3'd0;
    localparam logic [2:0] OpBeq  = 3'd1;
    localparam logic [2:0] OpBne  = 3'd2;
    localparam logic [2:0] OpBltz = 3'd3;
    localparam logic [2:0] OpBgez = 3'd4;
    localparam logic [2:0] OpBgtz = 3'd5;
    localparam logic [2:0] OpBlez = 3'd6;

    logic [31:0] pcPlus4F;
    logic [31:0] branchOffsetD;
    logic [31:0] branchTargetD;
    logic [31:0] jumpTargetD;
    logic [31:0] targetD;
    logic        takenD;

    // Sequential PC, wrapping naturally at 32 bits.
    assign pcPlus4F = PCF + 32'd4;

    // Branch condition evaluation from the rs/rt comparator flags.
    // Op 7 is reserved and behaves like "no branch".
    always_comb begin
        takenD = 1'b0;
        case (BranchOpD)
            OpNone: takenD = 1'b0;
            OpBeq:  takenD = EqualD;
            OpBne:  takenD = !EqualD;
            OpBltz: takenD = LtzD;
            OpBgez: takenD = !LtzD;
            OpBgtz: takenD = !LtzD && !EqualD;
            OpBlez: takenD = LtzD || EqualD;
            default: takenD = 1'b0;
        endcase
    end

    // A stalled D stage holds a stale decision, so it never redirects.
    assign RedirectD = !StallD && (JumpD || JrD || takenD);

    assign branchOffsetD = {{14{InstrD[15]}}, InstrD[15:0], 2'b00};
    assign branchTargetD = PCPlus4D + branchOffsetD;
    assign jumpTargetD   = {PCPlus4D[31:28], InstrD[25:0], 2'b00};

    // Target select: register jump wins over direct jump, which wins over
    // a conditional branch. The jr target is used unmodified.
    always_comb begin
        targetD = branchTargetD;
        if (JrD) begin
            targetD = JrTargetD;
        end else if (JumpD) begin
            targetD = jumpTargetD;
        end
    end

    // Program counter: a redirect overrides a fetch stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else if (RedirectD) begin
            PCF <= targetD;
        end else if (!StallF) begin
            PCF <= pcPlus4F;
        end
    end

    // IF/ID register: hold on StallD, squash wrong-path fetch if configured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD   <= 32'h0;
            PCPlus4D <= 32'h0;
        end else if (StallD) begin
            InstrD   <= InstrD;
            PCPlus4D <= PCPlus4D;
        end else if (RedirectD && SquashOnRedirect) begin
            InstrD   <= 32'h0;
            PCPlus4D <= 32'h0;
        end else begin
            InstrD   <= InstrF;
            PCPlus4D <= pcPlus4F;
        end
    end

    // Saturating count of taken redirects since reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BranchCountD <= 16'h0;
        end else if (RedirectD && (BranchCountD != 16'hFFFF)) begin
            BranchCountD <= BranchCountD + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Self-checking bench for fetch_branch_unit. Two instances share stimulus:
// index 0 squashes on redirect, index 1 has a MIPS delay slot. A behavioural
// model (per-instance PC / IF/ID / counter) predicts every registered output.
module tb_fetch_branch_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus and DUT outputs ----------------
    logic [31:0] InstrF = '0;
    logic [31:0] JrTargetD = '0;
    logic        StallF = 1'b0, StallD = 1'b0, JumpD = 1'b0, JrD = 1'b0;
    logic        EqualD = 1'b0, LtzD = 1'b0;
    logic [2:0]  BranchOpD = '0;

    logic [31:0] pcF[2];
    logic [31:0] instrD[2];
    logic [31:0] pc4D[2];
    logic        redir[2];
    logic [15:0] cnt[2];

    int total = 0;
    int bad = 0;

    fetch_branch_unit #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(0)) dut0 (
        .clk(clk), .reset(reset), .InstrF(InstrF), .PCF(pcF[0]),
        .StallF(StallF), .StallD(StallD), .BranchOpD(BranchOpD),
        .JumpD(JumpD), .JrD(JrD), .EqualD(EqualD), .LtzD(LtzD),
        .JrTargetD(JrTargetD), .InstrD(instrD[0]), .PCPlus4D(pc4D[0]),
        .RedirectD(redir[0]), .BranchCountD(cnt[0])
    );

    fetch_branch_unit #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1)) dut1 (
        .clk(clk), .reset(reset), .InstrF(InstrF), .PCF(pcF[1]),
        .StallF(StallF), .StallD(StallD), .BranchOpD(BranchOpD),
        .JumpD(JumpD), .JrD(JrD), .EqualD(EqualD), .LtzD(LtzD),
        .JrTargetD(JrTargetD), .InstrD(instrD[1]), .PCPlus4D(pc4D[1]),
        .RedirectD(redir[1]), .BranchCountD(cnt[1])
    );

    // ---------------- reference model ----------------
    logic [31:0] mPc[2];
    logic [31:0] mInstr[2];
    logic [31:0] mPc4[2];
    logic [15:0] mCnt[2];

    // Branch outcome expressed as a three-way relation lt / eq / gt.
    function automatic bit modelTaken(input logic [2:0] op, input logic eq, input logic ltz);
        bit lt, gt;
        lt = ltz;
        gt = !ltz && !eq;
        case (op)
            3'd1: return eq;
            3'd2: return !eq;
            3'd3: return lt;
            3'd4: return !lt;
            3'd5: return gt;
            3'd6: return !gt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit modelRedirect();
        return !StallD && (JumpD || JrD || modelTaken(BranchOpD, EqualD, LtzD));
    endfunction

    function automatic logic [31:0] modelTarget(input int i);
        logic [31:0] off;
        if (JrD) return JrTargetD;
        if (JumpD) return {mPc4[i][31:28], mInstr[i][25:0], 2'b00};
        off = 32'($signed(mInstr[i][15:0]));
        return mPc4[i] + off * 32'd4;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mPc[i] = 32'h0000_3000;
            mInstr[i] = 32'h0;
            mPc4[i] = 32'h0;
            mCnt[i] = 16'h0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clearControls();
        StallF = 1'b0; StallD = 1'b0; JumpD = 1'b0; JrD = 1'b0;
        EqualD = 1'b0; LtzD = 1'b0; BranchOpD = 3'd0; JrTargetD = 32'h0;
    endtask

    // Advance one clock edge; the model takes the inputs present at the edge.
    task automatic step();
        logic [31:0] nPc[2], nInstr[2], nPc4[2];
        logic [15:0] nCnt[2];
        bit r;
        r = modelRedirect();
        for (int i = 0; i < 2; i++) begin
            nPc[i] = r ? modelTarget(i) : (StallF ? mPc[i] : mPc[i] + 32'd4);
            if (StallD) begin
                nInstr[i] = mInstr[i]; nPc4[i] = mPc4[i];
            end else if (r && i == 0) begin
                nInstr[i] = 32'h0; nPc4[i] = 32'h0;
            end else begin
                nInstr[i] = InstrF; nPc4[i] = mPc[i] + 32'd4;
            end
            nCnt[i] = (r && mCnt[i] != 16'hFFFF) ? mCnt[i] + 16'd1 : mCnt[i];
        end
        @(posedge clk);
        if (reset) begin
            modelReset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                mPc[i] = nPc[i]; mInstr[i] = nInstr[i]; mPc4[i] = nPc4[i]; mCnt[i] = nCnt[i];
            end
        end
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        clearControls();
        #1;
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        doReset();
        for (int i = 0; i < 2; i++) begin
            total++; if (pcF[i] !== 32'h3000) begin bad++; $display("FAIL reset_pc[%0d]: got %h want %h", i, pcF[i], 32'h3000); end
            total++; if (instrD[i] !== 32'h0) begin bad++; $display("FAIL reset_instr[%0d]: got %h want 0", i, instrD[i]); end
            total++; if (pc4D[i] !== 32'h0) begin bad++; $display("FAIL reset_pc4[%0d]: got %h want 0", i, pc4D[i]); end
            total++; if (cnt[i] !== 16'h0) begin bad++; $display("FAIL reset_cnt[%0d]: got %h want 0", i, cnt[i]); end
        end
    endtask

    task automatic test_free_run();
        logic [31:0] v;
        logic [31:0] expPc;
        doReset();
        for (int k = 0; k < 3; k++) begin
            v = $urandom;
            InstrF = v;
            step();
            expPc = 32'h3004 + 32'(4 * k);
            total++; if (pcF[0] !== expPc) begin bad++; $display("FAIL free_pc: got %h want %h", pcF[0], expPc); end
            total++; if (instrD[0] !== v) begin bad++; $display("FAIL free_instr: got %h want %h", instrD[0], v); end
            total++; if (pc4D[0] !== expPc) begin bad++; $display("FAIL free_pc4: got %h want %h", pc4D[0], expPc); end
        end
    endtask

    task automatic test_beq();
        logic [31:0] v;
        doReset();
        for (int k = 0; k < 4; k++) begin
            InstrF = (k == 3) ? 32'h1000_FFFE : $urandom;
            step();
        end
        total++; if (pc4D[0] !== 32'h3010) begin bad++; $display("FAIL beq_setup_pc4: got %h want %h", pc4D[0], 32'h3010); end
        BranchOpD = 3'd1; EqualD = 1'b1; InstrF = $urandom;
        #1;
        total++; if (redir[0] !== 1'b1) begin bad++; $display("FAIL beq_redirect: got %b want 1", redir[0]); end
        step();
        total++; if (pcF[0] !== 32'h3008) begin bad++; $display("FAIL beq_target: got %h want %h", pcF[0], 32'h3008); end
        total++; if (instrD[0] !== 32'h0) begin bad++; $display("FAIL beq_squash: got %h want 0", instrD[0]); end
        total++; if (cnt[0] !== 16'd1) begin bad++; $display("FAIL beq_count: got %0d want 1", cnt[0]); end
        EqualD = 1'b0; v = $urandom; InstrF = v;
        #1;
        total++; if (redir[0] !== 1'b0) begin bad++; $display("FAIL beq_not_taken: got %b want 0", redir[0]); end
        step();
        total++; if (pcF[0] !== 32'h300C) begin bad++; $display("FAIL beq_nt_pc: got %h want %h", pcF[0], 32'h300C); end
        total++; if (instrD[0] !== v) begin bad++; $display("FAIL beq_nt_instr: got %h want %h", instrD[0], v); end
        total++; if (cnt[0] !== 16'd1) begin bad++; $display("FAIL beq_nt_count: got %0d want 1", cnt[0]); end
        clearControls();
    endtask

    task automatic test_branch_matrix();
        // Bit c of each entry: c=0 (eq=0,ltz=0), c=1 (eq=0,ltz=1), c=2 (eq=1,ltz=0).
        logic [2:0] expTab[8];
        logic exp;
        expTab[0] = 3'b000; expTab[1] = 3'b100; expTab[2] = 3'b011; expTab[3] = 3'b010;
        expTab[4] = 3'b101; expTab[5] = 3'b001; expTab[6] = 3'b110; expTab[7] = 3'b000;
        for (int op = 1; op < 8; op++) begin
            for (int c = 0; c < 3; c++) begin
                BranchOpD = 3'(op);
                EqualD = (c == 2);
                LtzD = (c == 1);
                InstrF = $urandom;
                #1;
                exp = expTab[op][c];
                total++; if (redir[0] !== exp) begin bad++; $display("FAIL matrix op%0d c%0d: got %b want %b", op, c, redir[0], exp); end
                step();
                total++; if (pcF[0] !== mPc[0]) begin bad++; $display("FAIL matrix_pc op%0d c%0d: got %h want %h", op, c, pcF[0], mPc[0]); end
            end
        end
        clearControls();
    endtask

    task automatic test_jr_priority();
        JrD = 1'b1; JrTargetD = 32'h0000_4000; JumpD = 1'b1;
        BranchOpD = 3'd1; EqualD = 1'b1; StallF = 1'b1; InstrF = $urandom;
        step();
        for (int i = 0; i < 2; i++) begin
            total++; if (pcF[i] !== 32'h4000) begin bad++; $display("FAIL jr_priority[%0d]: got %h want %h", i, pcF[i], 32'h4000); end
        end
        clearControls();
    endtask

    task automatic test_stall_d();
        logic [31:0] expI, expP, tgt;
        logic [15:0] expC;
        InstrF = 32'h1000_0010;
        step();
        BranchOpD = 3'd1; EqualD = 1'b1; StallD = 1'b1; StallF = 1'b1;
        InstrF = $urandom;
        expI = mInstr[0]; expP = mPc4[0]; expC = mCnt[0];
        #1;
        total++; if (redir[0] !== 1'b0) begin bad++; $display("FAIL stall_redirect: got %b want 0", redir[0]); end
        step();
        total++; if (instrD[0] !== expI) begin bad++; $display("FAIL stall_instr: got %h want %h", instrD[0], expI); end
        total++; if (pc4D[0] !== expP) begin bad++; $display("FAIL stall_pc4: got %h want %h", pc4D[0], expP); end
        total++; if (cnt[0] !== expC) begin bad++; $display("FAIL stall_count: got %h want %h", cnt[0], expC); end
        StallD = 1'b0; StallF = 1'b0;
        #1;
        total++; if (redir[0] !== 1'b1) begin bad++; $display("FAIL unstall_redirect: got %b want 1", redir[0]); end
        tgt = expP + 32'h40;
        step();
        total++; if (pcF[0] !== tgt) begin bad++; $display("FAIL unstall_target: got %h want %h", pcF[0], tgt); end
        total++; if (cnt[0] !== expC + 16'd1) begin bad++; $display("FAIL unstall_count: got %h want %h", cnt[0], expC + 16'd1); end
        clearControls();
    endtask

    task automatic test_delay_slot();
        logic [31:0] ds;
        doReset();
        InstrF = $urandom;
        step();
        InstrF = 32'h0800_0400;
        step();
        total++; if (pc4D[1] !== 32'h3008) begin bad++; $display("FAIL ds_setup_pc4: got %h want %h", pc4D[1], 32'h3008); end
        JumpD = 1'b1;
        ds = $urandom | 32'h1;
        InstrF = ds;
        step();
        total++; if (pcF[1] !== 32'h1000) begin bad++; $display("FAIL ds_target: got %h want %h", pcF[1], 32'h1000); end
        total++; if (instrD[1] !== ds) begin bad++; $display("FAIL ds_slot_instr: got %h want %h", instrD[1], ds); end
        total++; if (pcF[0] !== 32'h1000) begin bad++; $display("FAIL nods_target: got %h want %h", pcF[0], 32'h1000); end
        total++; if (instrD[0] !== 32'h0) begin bad++; $display("FAIL nods_squash: got %h want 0", instrD[0]); end
        clearControls();
        step();
        step();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            total++; if (pcF[i] !== 32'h3000) begin bad++; $display("FAIL async_reset_pc[%0d]: got %h want %h", i, pcF[i], 32'h3000); end
            total++; if (cnt[i] !== 16'h0) begin bad++; $display("FAIL async_reset_cnt[%0d]: got %h want 0", i, cnt[i]); end
        end
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_pc_wrap();
        JrD = 1'b1; JrTargetD = 32'hFFFF_FFFC; InstrF = $urandom;
        step();
        total++; if (pcF[0] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_jr: got %h want %h", pcF[0], 32'hFFFF_FFFC); end
        clearControls();
        InstrF = $urandom;
        step();
        total++; if (pcF[0] !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want 0", pcF[0]); end
        total++; if (pc4D[1] !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h want 0", pc4D[1]); end
    endtask

    task automatic test_random();
        bit r;
        doReset();
        for (int n = 0; n < 400; n++) begin
            StallF = ($urandom_range(0, 5) == 0);
            StallD = ($urandom_range(0, 5) == 0);
            JumpD = ($urandom_range(0, 9) == 0);
            JrD = ($urandom_range(0, 11) == 0);
            BranchOpD = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            EqualD = 1'($urandom);
            LtzD = 1'($urandom);
            JrTargetD = $urandom;
            InstrF = $urandom;
            #1;
            r = modelRedirect();
            for (int i = 0; i < 2; i++) begin
                total++; if (redir[i] !== r) begin bad++; $display("FAIL rnd_redirect[%0d] n=%0d: got %b want %b", i, n, redir[i], r); end
            end
            step();
            for (int i = 0; i < 2; i++) begin
                total++; if (pcF[i] !== mPc[i]) begin bad++; $display("FAIL rnd_pc[%0d] n=%0d: got %h want %h", i, n, pcF[i], mPc[i]); end
                total++; if (instrD[i] !== mInstr[i]) begin bad++; $display("FAIL rnd_instr[%0d] n=%0d: got %h want %h", i, n, instrD[i], mInstr[i]); end
                total++; if (pc4D[i] !== mPc4[i]) begin bad++; $display("FAIL rnd_pc4[%0d] n=%0d: got %h want %h", i, n, pc4D[i], mPc4[i]); end
                total++; if (cnt[i] !== mCnt[i]) begin bad++; $display("FAIL rnd_cnt[%0d] n=%0d: got %h want %h", i, n, cnt[i], mCnt[i]); end
            end
        end
        clearControls();
    endtask

    task automatic test_saturation();
        doReset();
        JumpD = 1'b1;
        for (int n = 0; n < 65534; n++) begin
            InstrF = 32'(n);
            step();
        end
        total++; if (cnt[0] !== 16'hFFFE) begin bad++; $display("FAIL sat_pre: got %h want %h", cnt[0], 16'hFFFE); end
        step();
        total++; if (cnt[0] !== 16'hFFFF) begin bad++; $display("FAIL sat_reach: got %h want %h", cnt[0], 16'hFFFF); end
        step();
        step();
        total++; if (cnt[0] !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want %h", cnt[0], 16'hFFFF); end
        total++; if (cnt[1] !== 16'hFFFF) begin bad++; $display("FAIL sat_hold_ds: got %h want %h", cnt[1], 16'hFFFF); end
        clearControls();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        modelReset();
        test_reset();
        test_free_run();
        test_beq();
        test_branch_matrix();
        test_jr_priority();
        test_stall_d();
        test_delay_slot();
        test_pc_wrap();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
